// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package rr_mux_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_mux_arbiter4_rr_pick4.sv
// Combinational round-robin pick: first set req bit at or after ptr (mod 4),
// optionally skipping excl_idx.
module rr_pick4
  import rr_mux_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       found,
  output logic [1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand] && !(excl_en && (cand == excl_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for one shared 4-input datapath; drives mux select and one-hot grant.
// Optional hold-limit pre-emption is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int         HOLD_MAX = 16,
  parameter int         CNT_W    = 5,
  parameter logic [1:0] SEL_PARK = 2'b00
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [3:0]       req_in,
  output logic [3:0]       gnt_out,
  output logic [1:0]       sel_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] hold_cnt_out
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  logic [3:0]       owner_mask;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_excl;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             preempt;

  assign owner_mask = 4'b0001 << owner;

  // While granted, the search starts just past the owner and skips it, so a
  // released or pre-empted owner is always lowest priority.
  assign pick_ptr  = (state == ST_GRANT) ? (owner + 2'd1) : rr_ptr;
  assign pick_excl = (state == ST_GRANT);

  rr_pick4 u_pick (
    .req      (req_in),
    .ptr      (pick_ptr),
    .excl_en  (pick_excl),
    .excl_idx (owner),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef ARB_HOLD_LIMIT_EN
  assign preempt = (state == ST_GRANT) && (hold_cnt == HOLD_LIM) &&
                   ((req_in & ~owner_mask) != 4'b0000);
`else
  logic [CNT_W-1:0] hold_lim_unused;
  assign hold_lim_unused = HOLD_LIM;
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt    = ST_GRANT;
          owner_nxt    = pick_idx;
          hold_cnt_nxt = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (!req_in[owner] || preempt) begin
          rr_ptr_nxt = owner + 2'd1;
          if (pick_found) begin
            owner_nxt    = pick_idx;
            hold_cnt_nxt = CNT_ONE;
          end else begin
            state_nxt    = ST_IDLE;
            owner_nxt    = '0;
            hold_cnt_nxt = '0;
          end
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_cnt_nxt = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so they change solely on clock or reset.
  always_comb begin
    busy_out     = (state == ST_GRANT);
    gnt_out      = busy_out ? owner_mask : 4'b0000;
    sel_out      = busy_out ? owner : SEL_PARK;
    hold_cnt_out = hold_cnt;
  end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Bench for rr_mux_arbiter4: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-free behavioural model (HOLD_MAX=4).
module tb_rr_mux_arbiter4;

  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic [3:0]       req_in = 4'b0000;
  logic [3:0]       gnt_out;
  logic [1:0]       sel_out;
  logic             busy_out;
  logic [CNT_W-1:0] hold_cnt_out;

  rr_mux_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W), .SEL_PARK(2'b00)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .req_in       (req_in),
    .gnt_out      (gnt_out),
    .sel_out      (sel_out),
    .busy_out     (busy_out),
    .hold_cnt_out (hold_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: who owns the resource, for how long, and where the next search starts.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input int c);
    check({tag, ".gnt"}, 32'(gnt_out), 32'(g));
    check({tag, ".sel"}, 32'(sel_out), 32'(s));
    check({tag, ".busy"}, 32'(busy_out), 32'(b));
    check({tag, ".cnt"}, 32'(hold_cnt_out), 32'(c));
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] cand;
    int base;
    if (!m_busy) begin
      base = m_ptr;
      cand = r;
    end else begin
      cand = r & ~(4'b0001 << m_owner);
      if (r[m_owner] && !(LIM && m_cnt == HOLD_MAX && cand != 4'b0000)) begin
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        return;
      end
      m_ptr = (m_owner + 1) % 4;
      base  = m_ptr;
    end
    m_busy = 0; m_owner = 0; m_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (cand[(base + k) % 4]) begin
        m_busy = 1; m_owner = (base + k) % 4; m_cnt = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #2;
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic edge_with(input logic [3:0] r);
    req_in = r;
    @(posedge clk_in);
    #1;
  endtask

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] gnt, logic [1:0] sel,
                              logic busy, int cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.sel = sel; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    logic [3:0] r;

    // Reset with all requests high keeps everything parked.
    rst_n_in = 1'b0;
    req_in   = 4'b1111;
    #12;
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 0);
    @(posedge clk_in);
    #1;
    check_outs("reset_clk", 4'b0000, 2'd0, 1'b0, 0);

    // Single requester, then rotation with back-to-back handover, then wrap 3->0.
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 2'd2, 1, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 2'd2, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b0001, 2'd0, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 2));
    vecs.push_back(mk(0, 4'b1110, 4'b0010, 2'd1, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 1, 2));
    vecs.push_back(mk(0, 4'b1101, 4'b0100, 2'd2, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0100, 2'd2, 1, 2));
    vecs.push_back(mk(0, 4'b1011, 4'b1000, 2'd3, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 2'd3, 1, 2));
    vecs.push_back(mk(0, 4'b0111, 4'b0001, 2'd0, 1, 1));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 1));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 2'd0, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      edge_with(vecs[i].req);
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].cnt);
    end

    // Hold limit: req2 joins while req0 owns; switch only with pre-emption enabled.
    do_reset();
    edge_with(4'b0001);
    edge_with(4'b0001);
    check_outs("hold_c2", 4'b0001, 2'd0, 1'b1, 2);
    edge_with(4'b0101);
    edge_with(4'b0101);
    check_outs("hold_c4", 4'b0001, 2'd0, 1'b1, 4);
    edge_with(4'b0101);
    if (LIM) check_outs("preempt", 4'b0100, 2'd2, 1'b1, 1);
    else     check_outs("no_preempt", 4'b0001, 2'd0, 1'b1, 5);

    // Lone owner saturates the counter and is never displaced.
    do_reset();
    repeat (40) edge_with(4'b0001);
    check_outs("saturate", 4'b0001, 2'd0, 1'b1, CNT_MAX);

    // Drive rr_ptr to 3 with owner 1, then reset between edges.
    do_reset();
    edge_with(4'b0001);
    edge_with(4'b0010);
    edge_with(4'b0100);
    edge_with(4'b0010);
    check_outs("pre_async", 4'b0010, 2'd1, 1'b1, 1);
    #1;
    rst_n_in = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 2'd0, 1'b0, 0);
    #1;
    rst_n_in = 1'b1;
    edge_with(4'b1010);
    check_outs("post_rst_ptr0", 4'b0010, 2'd1, 1'b1, 1);

    // Randomized traffic against the model.
    do_reset();
    r = 4'b0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        check_outs("rand_rst", 4'b0000, 2'd0, 1'b0, 0);
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
      end
      edge_with(r);
      model_edge(r);
      check_outs($sformatf("rand%0d", cyc),
                 m_busy ? (4'b0001 << m_owner) : 4'b0000,
                 m_busy ? 2'(m_owner) : 2'd0, m_busy, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
